// File: rtl/ram_arbiter_2x.sv
// ram_arbiter_2x: two-requester arbiter in front of a single-port synchronous RAM.
// One transaction in flight at a time: IDLE samples requests, ISSUE drives the
// RAM command for one cycle, CAPTURE (reads only) collects ram_dout.
// Ports:
//   clk, rst_n                  clock, async active-low reset
//   req/we/addr/wdata{0,1}      requester commands, sampled only at the grant edge
//   gnt{0,1}                    one-cycle grant pulse (the ISSUE cycle)
//   rvalid{0,1}, rdata{0,1}     read return; rdata held until the next rvalid
//   busy                        high whenever not IDLE
//   ram_en, ram_addr, ram_din   RAM command (ram_en=1 means write)
//   ram_dout                    RAM read data, valid the cycle after the address
module ram_arbiter_2x #(
  parameter int ADDR_W = 2,
  parameter int DATA_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0,
  input  logic              req1,
  input  logic              we0,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  output logic              gnt0,
  output logic              gnt1,
  output logic              rvalid0,
  output logic              rvalid1,
  output logic [DATA_W-1:0] rdata0,
  output logic [DATA_W-1:0] rdata1,
  output logic              busy,
  output logic              ram_en,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_din,
  input  logic [DATA_W-1:0] ram_dout
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    CAPTURE = 2'd2
  } state_t;

  state_t r_state, w_state_nxt;

  // r_prio: 1 = requester 1 wins the next tie. r_id/r_we: latched winner and
  // direction; the latched address/data live directly in r_ram_addr/r_ram_din.
  logic              r_prio,    w_prio_nxt;
  logic              r_id,      w_id_nxt;
  logic              r_we,      w_we_nxt;
  logic              r_gnt0,    w_gnt0_nxt;
  logic              r_gnt1,    w_gnt1_nxt;
  logic              r_rvalid0, w_rvalid0_nxt;
  logic              r_rvalid1, w_rvalid1_nxt;
  logic [DATA_W-1:0] r_rdata0,  w_rdata0_nxt;
  logic [DATA_W-1:0] r_rdata1,  w_rdata1_nxt;
  logic              r_busy,    w_busy_nxt;
  logic              r_ram_en,  w_ram_en_nxt;
  logic [ADDR_W-1:0] r_ram_addr, w_ram_addr_nxt;
  logic [DATA_W-1:0] r_ram_din,  w_ram_din_nxt;

  // Requester 1 wins when alone, or on a tie when it holds the priority.
  logic w_pick1;
  assign w_pick1 = req1 & (~req0 | r_prio);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_prio_nxt     = r_prio;
    w_id_nxt       = r_id;
    w_we_nxt       = r_we;
    w_gnt0_nxt     = 1'b0;
    w_gnt1_nxt     = 1'b0;
    w_rvalid0_nxt  = 1'b0;
    w_rvalid1_nxt  = 1'b0;
    w_rdata0_nxt   = r_rdata0;
    w_rdata1_nxt   = r_rdata1;
    w_busy_nxt     = 1'b0;
    w_ram_en_nxt   = 1'b0;
    w_ram_addr_nxt = r_ram_addr;
    w_ram_din_nxt  = r_ram_din;
    case (r_state)
      IDLE: begin
        if (req0 | req1) begin
          w_state_nxt    = ISSUE;
          w_busy_nxt     = 1'b1;
          w_id_nxt       = w_pick1;
          w_prio_nxt     = ~w_pick1;
          w_gnt0_nxt     = ~w_pick1;
          w_gnt1_nxt     = w_pick1;
          w_we_nxt       = w_pick1 ? we1    : we0;
          w_ram_en_nxt   = w_pick1 ? we1    : we0;
          w_ram_addr_nxt = w_pick1 ? addr1  : addr0;
          w_ram_din_nxt  = w_pick1 ? wdata1 : wdata0;
        end
      end
      ISSUE: begin
        // Write commits at this edge inside the RAM; a read keeps the address
        // up while ram_dout becomes valid.
        if (r_we) begin
          w_state_nxt = IDLE;
        end else begin
          w_state_nxt = CAPTURE;
          w_busy_nxt  = 1'b1;
        end
      end
      CAPTURE: begin
        w_state_nxt = IDLE;
        if (r_id) begin
          w_rdata1_nxt  = ram_dout;
          w_rvalid1_nxt = 1'b1;
        end else begin
          w_rdata0_nxt  = ram_dout;
          w_rvalid0_nxt = 1'b1;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_prio     <= 1'b0;
      r_id       <= 1'b0;
      r_we       <= 1'b0;
      r_gnt0     <= 1'b0;
      r_gnt1     <= 1'b0;
      r_rvalid0  <= 1'b0;
      r_rvalid1  <= 1'b0;
      r_rdata0   <= '0;
      r_rdata1   <= '0;
      r_busy     <= 1'b0;
      r_ram_en   <= 1'b0;
      r_ram_addr <= '0;
      r_ram_din  <= '0;
    end else begin
      r_prio     <= w_prio_nxt;
      r_id       <= w_id_nxt;
      r_we       <= w_we_nxt;
      r_gnt0     <= w_gnt0_nxt;
      r_gnt1     <= w_gnt1_nxt;
      r_rvalid0  <= w_rvalid0_nxt;
      r_rvalid1  <= w_rvalid1_nxt;
      r_rdata0   <= w_rdata0_nxt;
      r_rdata1   <= w_rdata1_nxt;
      r_busy     <= w_busy_nxt;
      r_ram_en   <= w_ram_en_nxt;
      r_ram_addr <= w_ram_addr_nxt;
      r_ram_din  <= w_ram_din_nxt;
    end
  end

  assign gnt0     = r_gnt0;
  assign gnt1     = r_gnt1;
  assign rvalid0  = r_rvalid0;
  assign rvalid1  = r_rvalid1;
  assign rdata0   = r_rdata0;
  assign rdata1   = r_rdata1;
  assign busy     = r_busy;
  assign ram_en   = r_ram_en;
  assign ram_addr = r_ram_addr;
  assign ram_din  = r_ram_din;

endmodule

// File: tb/tb_ram_arbiter_2x.sv
// Bench for ram_arbiter_2x: directed scenarios with literal expectations, then
// randomized requesters; a transaction-level schedule model predicts every
// output cycle by cycle and a negedge process compares against it.
module tb_ram_arbiter_2x;
  localparam int AW = 2;
  localparam int DW = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          req0 = 1'b0, req1 = 1'b0, we0 = 1'b0, we1 = 1'b0;
  logic [AW-1:0] addr0 = '0, addr1 = '0;
  logic [DW-1:0] wdata0 = '0, wdata1 = '0;
  logic          gnt0, gnt1, rvalid0, rvalid1, busy, ram_en;
  logic [DW-1:0] rdata0, rdata1, ram_din, ram_dout;
  logic [AW-1:0] ram_addr;

  always #5 clk = ~clk;

  ram_arbiter_2x #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
    .rdata0(rdata0), .rdata1(rdata1), .busy(busy),
    .ram_en(ram_en), .ram_addr(ram_addr), .ram_din(ram_din), .ram_dout(ram_dout)
  );

  // Synchronous RAM: write on ram_en, registered read of the presented address.
  logic [DW-1:0] ram [4] = '{default: '0};
  always @(posedge clk) begin
    if (ram_en) ram[ram_addr] <= ram_din;
    ram_dout <= ram[ram_addr];
  end

  int errors = 0;
  int checks = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Each grant at edge n schedules what the following cycles must show:
  // slot n = grant cycle, n+1 = read wait, n+2 = read return.
  typedef struct {
    bit g0, g1, en, busy, rv0, rv1, achk;
    logic [AW-1:0] a;
    logic [DW-1:0] d, rd;
  } slot_t;

  slot_t         sl [4];
  slot_t         e;
  logic [DW-1:0] e_rd0, e_rd1;
  logic [DW-1:0] smem [4] = '{default: '0};
  int            n, free_at;
  bit            ptr;       // requester preferred on the next tie
  bit            pw;        // write waiting to commit
  int            pw_at;
  logic [AW-1:0] pw_addr;
  logic [DW-1:0] pw_data;

  initial begin
    bit            w, wv;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    int            k;
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        n = 0; free_at = 0; ptr = 1'b0; pw = 1'b0;
        for (int i = 0; i < 4; i++) sl[i] = '{default: 0};
        e = '{default: 0};
        e_rd0 = '0; e_rd1 = '0;
      end else begin
        n++;
        if (pw && pw_at == n) begin smem[pw_addr] = pw_data; pw = 1'b0; end
        if (n >= free_at && (req0 || req1)) begin
          w   = (req0 && req1) ? ptr : req1;
          ptr = !w;
          wv  = w ? we1 : we0;
          a   = w ? addr1 : addr0;
          d   = w ? wdata1 : wdata0;
          k   = n % 4;
          sl[k].g0 = !w; sl[k].g1 = w; sl[k].en = wv; sl[k].busy = 1'b1;
          sl[k].achk = 1'b1; sl[k].a = a; sl[k].d = d;
          if (wv) begin
            pw = 1'b1; pw_at = n + 1; pw_addr = a; pw_data = d;
            free_at = n + 2;
          end else begin
            k = (n + 1) % 4;
            sl[k].busy = 1'b1; sl[k].achk = 1'b1; sl[k].a = a;
            k = (n + 2) % 4;
            sl[k].rv0 = !w; sl[k].rv1 = w; sl[k].rd = smem[a];
            free_at = n + 3;
          end
        end
        k = n % 4;
        e = sl[k];
        if (e.rv0) e_rd0 = e.rd;
        if (e.rv1) e_rd1 = e.rd;
        sl[k] = '{default: 0};
      end
    end
  end

  // Every cycle out of reset: all outputs against the model.
  initial forever begin
    @(negedge clk);
    if (rst_n) begin
      chk("ctrl{g0,g1,rv0,rv1,busy,en}",
          32'({gnt0, gnt1, rvalid0, rvalid1, busy, ram_en}),
          32'({e.g0, e.g1, e.rv0, e.rv1, e.busy, e.en}));
      chk("rdata0", 32'(rdata0), 32'(e_rd0));
      chk("rdata1", 32'(rdata1), 32'(e_rd1));
      if (e.achk) chk("ram_addr", 32'(ram_addr), 32'(e.a));
      if (e.en)   chk("ram_din", 32'(ram_din), 32'(e.d));
    end
  end

  // ---------------- directed helpers ----------------
  function automatic logic [31:0] all_outs();
    return 32'({gnt0, gnt1, rvalid0, rvalid1, busy, ram_en, ram_addr, ram_din, rdata0, rdata1});
  endfunction

  task automatic txn(input bit id, input bit we, input logic [AW-1:0] a,
                     input logic [DW-1:0] d, output logic [DW-1:0] rd);
    bit ok = 1'b0;
    rd = '0;
    if (id) begin req1 = 1'b1; we1 = we; addr1 = a; wdata1 = d; end
    else    begin req0 = 1'b1; we0 = we; addr0 = a; wdata0 = d; end
    for (int i = 0; i < 12 && !ok; i++) begin
      @(posedge clk); #1;
      ok = id ? gnt1 : gnt0;
    end
    chk("txn_gnt", 32'(ok), 32'd1);
    if (id) req1 = 1'b0; else req0 = 1'b0;
    if (!we && ok) begin
      ok = 1'b0;
      for (int i = 0; i < 4 && !ok; i++) begin
        @(posedge clk); #1;
        ok = id ? rvalid1 : rvalid0;
      end
      chk("txn_rvalid", 32'(ok), 32'd1);
      rd = id ? rdata1 : rdata0;
    end
  endtask

  logic [DW-1:0] vals [4] = '{4'b1010, 4'b1100, 4'b0101, 4'b1111};

  initial begin
    logic [DW-1:0] rd;
    int            order [$];
    bit            act [2];
    int            waitc [2];
    bit            g;

    // reset state
    #3 chk("reset_outs", all_outs(), 32'd0);
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;

    // single write: 1100 to address 01
    req0 = 1'b1; we0 = 1'b1; addr0 = 2'b01; wdata0 = 4'b1100;
    @(posedge clk); #1;
    chk("w_gnt0", 32'(gnt0), 32'd1);
    chk("w_issue{en,addr,din,busy}", 32'({ram_en, ram_addr, ram_din, busy}), 32'b1_01_1100_1);
    req0 = 1'b0;
    @(posedge clk); #1;
    chk("w_after{gnt0,busy,en}", 32'({gnt0, busy, ram_en}), 32'd0);

    // read-back by requester 1
    req1 = 1'b1; we1 = 1'b0; addr1 = 2'b01;
    @(posedge clk); #1;
    chk("r_gnt1_en", 32'({gnt1, ram_en}), 32'b10);
    req1 = 1'b0;
    @(posedge clk); #1;
    chk("r_capture{en,addr,busy}", 32'({ram_en, ram_addr, busy}), 32'b0_01_1);
    @(posedge clk); #1;
    chk("r_rvalid{rv0,rv1}", 32'({rvalid0, rvalid1}), 32'b01);
    chk("r_rdata1", 32'(rdata1), 32'b1100);

    // tie after reset: strict alternation starting at requester 0
    rst_n = 1'b0; #1; @(posedge clk); #2 rst_n = 1'b1;
    req0 = 1'b1; we0 = 1'b1; addr0 = 2'd3; wdata0 = 4'b1111;
    req1 = 1'b1; we1 = 1'b1; addr1 = 2'd3; wdata1 = 4'b1111;
    for (int i = 0; i < 12 && order.size() < 4; i++) begin
      @(posedge clk); #1;
      if (gnt0) order.push_back(0);
      if (gnt1) order.push_back(1);
    end
    req0 = 1'b0; req1 = 1'b0;
    chk("tie_count", 32'(order.size()), 32'd4);
    for (int i = 0; i < order.size(); i++) chk("tie_order", 32'(order[i]), 32'(i % 2));
    @(posedge clk); #1;

    // fill by requester 0, dump by requester 1
    for (int i = 0; i < 4; i++) txn(1'b0, 1'b1, AW'(i), vals[i], rd);
    for (int i = 0; i < 4; i++) begin
      txn(1'b1, 1'b0, AW'(i), '0, rd);
      chk("dump_rdata1", 32'(rd), 32'(vals[i]));
    end

    // reset during ISSUE of write 0110 -> address 2
    req0 = 1'b1; we0 = 1'b1; addr0 = 2'd2; wdata0 = 4'b0110;
    @(posedge clk); #1;
    chk("rst_issue{gnt0,en}", 32'({gnt0, ram_en}), 32'b11);
    rst_n = 1'b0; req0 = 1'b0;
    #1 chk("rst_mid_outs", all_outs(), 32'd0);
    @(posedge clk); #2 rst_n = 1'b1;
    txn(1'b1, 1'b0, 2'd2, '0, rd);
    chk("rst_addr2_kept", 32'(rd), 32'b0101);

    // request pulse from requester 1 while requester 0 reads
    req0 = 1'b1; we0 = 1'b0; addr0 = 2'd0;
    @(posedge clk); #1;
    chk("bi_gnt0", 32'(gnt0), 32'd1);
    req0 = 1'b0;
    req1 = 1'b1; we1 = 1'b1; addr1 = 2'd0; wdata1 = 4'b0000;
    @(posedge clk); #1;
    chk("bi_capture{gnt1,en}", 32'({gnt1, ram_en}), 32'd0);
    @(posedge clk); #1;
    chk("bi_ret{gnt1,en,rv0}", 32'({gnt1, ram_en, rvalid0}), 32'b001);
    chk("bi_rdata0", 32'(rdata0), 32'b1010);
    req1 = 1'b0;
    @(posedge clk); #1;
    chk("bi_no_gnt1{gnt1,en}", 32'({gnt1, ram_en}), 32'd0);

    // randomized requesters obeying hold-until-grant
    act = '{0, 0}; waitc = '{0, 0};
    for (int c = 0; c < 3000; c++) begin
      @(posedge clk); #1;
      for (int id = 0; id < 2; id++) begin
        g = (id == 1) ? gnt1 : gnt0;
        if (act[id] && g) begin
          chk("fair_wait_ok", 32'(waitc[id] <= 8), 32'd1);
          act[id] = 1'b0;
          if (id == 1) req1 = 1'b0; else req0 = 1'b0;
        end else if (act[id]) begin
          waitc[id]++;
          if (waitc[id] > 20) begin
            chk("grant_timeout", 32'(waitc[id]), 32'd0);
            act[id] = 1'b0;
            if (id == 1) req1 = 1'b0; else req0 = 1'b0;
          end
        end else if ($urandom_range(0, 2) == 0) begin
          act[id] = 1'b1; waitc[id] = 0;
          if (id == 1) begin
            req1 = 1'b1; we1 = 1'($urandom); addr1 = AW'($urandom); wdata1 = DW'($urandom);
          end else begin
            req0 = 1'b1; we0 = 1'($urandom); addr0 = AW'($urandom); wdata0 = DW'($urandom);
          end
        end
      end
    end
    req0 = 1'b0; req1 = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/ram_arbiter_2x.md
RAM_ARBITER_2X -- requirements
Module: ram_arbiter_2x

Interface
REQ-001 SHALL have parameter ADDR_W, default 2, RAM address width.
REQ-002 SHALL have parameter DATA_W, default 4, RAM data width.
REQ-003 SHALL have port clk, input, 1, single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n, input, 1, reset; asynchronous, active-low.
REQ-005 SHALL have ports req0/req1, input, 1, access request from requester 0/1.
REQ-006 SHALL have ports we0/we1, input, 1, 1 = write, 0 = read; qualified by reqN.
REQ-007 SHALL have ports addr0/addr1, input, ADDR_W, access address.
REQ-008 SHALL have ports wdata0/wdata1, input, DATA_W, write data.
REQ-009 SHALL have ports gnt0/gnt1, output, 1, one-cycle grant pulse.
REQ-010 SHALL have ports rvalid0/rvalid1, output, 1, one-cycle read-data-valid pulse.
REQ-011 SHALL have ports rdata0/rdata1, output, DATA_W, read data; held until next rvalid on that port.
REQ-012 SHALL have port busy, output, 1, high whenever state is not IDLE.
REQ-013 SHALL have port ram_en, output, 1, RAM write enable (1 = write, 0 = read).
REQ-014 SHALL have ports ram_addr (ADDR_W) and ram_din (DATA_W), outputs, RAM address and write data.
REQ-015 SHALL have port ram_dout, input, DATA_W, RAM read data; valid in the cycle after a read address is presented.

Function
REQ-016 SHALL implement FSM states IDLE, ISSUE, CAPTURE; all outputs registered.
REQ-017 IDLE: at an edge where req0 or req1 is high, SHALL select one winner, latch its we/addr/wdata and requester ID, move to ISSUE, and drive gntN=1 for exactly the ISSUE cycle.
REQ-018 IDLE with no request: SHALL stay in IDLE, gnt0=gnt1=0.
REQ-019 Arbitration: a single requester SHALL win; on a tie the requester not granted most recently SHALL win (round-robin pointer).
REQ-020 The pointer SHALL update only on a grant; after reset requester 0 SHALL win the first tie.
REQ-021 ISSUE: ram_en, ram_addr, ram_din SHALL equal the latched command for exactly one cycle; latched write -> IDLE, latched read -> CAPTURE.
REQ-022 CAPTURE: SHALL drive ram_en=0 and hold ram_addr; at the closing edge rdataN <= ram_dout and rvalidN=1 for one cycle for the latched requester; state -> IDLE.
REQ-023 In IDLE and CAPTURE, ram_en SHALL be 0; no RAM write occurs outside ISSUE.
REQ-024 Latency: gnt 1 cycle after the sampling edge; write committed at the end of ISSUE; rvalid 3 cycles after the sampling edge.
REQ-025 Throughput: at most one transaction in flight; a write occupies 2 cycles, a read occupies 3, including the IDLE sampling cycle.
REQ-026 Requesters SHALL hold reqN, weN, addrN and wdataN stable until gntN is seen; the arbiter samples them only at the grant edge, and reqN may drop in the gnt cycle.
REQ-027 Requests arriving while busy=1 SHALL be ignored until IDLE; no queuing.
REQ-028 Fairness: a continuously asserted req SHALL be granted within at most one intervening transaction of the other requester.
REQ-029 The rdata of the non-served requester SHALL be unchanged by a transaction.

Reset
REQ-030 rst_n low SHALL immediately force: state IDLE, gnt0/1=0, rvalid0/1=0, rdata0/1=0, busy=0, ram_en=0, ram_addr=0, ram_din=0, pointer = requester 0 preferred.
REQ-031 Reset asserted during ISSUE SHALL abort the access; no RAM write is issued after reset assertion.
REQ-032 After rst_n deasserts, the first rising edge SHALL be a normal IDLE sampling edge.

Verification
REQ-033 Single write: req0=1, we0=1, addr0=2'b01, wdata0=4'b1100 -> gnt0 pulses next cycle; ISSUE shows ram_en=1, ram_addr=01, ram_din=1100; busy high for 1 cycle.
REQ-034 Read-back: after REQ-033, req1=1, we1=0, addr1=01 -> gnt1, then ram_en=0 and ram_addr=01, then rvalid1=1 with rdata1=1100; rvalid0 stays 0.
REQ-035 Tie after reset: req0 and req1 high together, held -> grant order gnt0, gnt1, gnt0, gnt1; never two consecutive grants to one port.
REQ-036 Fill and dump: requester 0 writes 1010/1100/0101/1111 to addresses 0..3, requester 1 reads 0..3 -> rdata1 sequence 1010, 1100, 0101, 1111.
REQ-037 Reset mid-write: rst_n low during ISSUE of write 0110 to address 2 -> all outputs 0 immediately; a later read of address 2 returns the prior value.
REQ-038 Busy ignore: req1 pulsed only during a requester-0 read -> no gnt1, no RAM access for requester 1.
